// File: rtl/obi_stream_reader.sv
// obi_stream_reader: OBI read manager that turns a (byte address, byte length)
// command into pipelined single-word OBI reads and delivers the returned
// words as a valid/ready stream with byte enables and a last flag.
// Optional feature macro: OBI_STREAM_READER_ERR_EN (sticky bus-error flag).
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and ready
// (or req and gnt) are both high; a source never drops valid/req, nor changes
// its payload, until that transfer has happened.

package obi_stream_reader_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        aid;
  } mgr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    mgr_obi_a_chan_t a;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        rid;
    logic        err;
  } mgr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    mgr_obi_r_chan_t r;
  } mgr_obi_rsp_t;
endpackage

module obi_stream_reader
  import obi_stream_reader_pkg::*;
#(
  parameter int FifoDepth = 4,
  parameter int LenWidth  = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                arvalid,
  output logic                arready,
  input  logic [31:0]         araddr,
  input  logic [LenWidth-1:0] arlen,
  output mgr_obi_req_t        mgr_req_o,
  input  mgr_obi_rsp_t        mgr_rsp_i,
  output logic                wvalid,
  input  logic                wready,
  output logic [31:0]         wdata,
  output logic [3:0]          wbe,
  output logic                wlast,
  output logic                busy_o,
  output logic                err_o
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = PtrW + 1;
  localparam int NW   = LenWidth + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DRAIN, ST_DONE} state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [NW-1:0]   nwords_q, nwords_d;
  logic [NW-1:0]   issue_cnt_q, issue_cnt_d;
  logic [NW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [1:0]      tail_q, tail_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic            err_q, err_d;
  logic [31:0]     mem_q [FifoDepth];

  logic            accept, req, issue, push, pop, credit;
  logic [NW-1:0]   cmd_nwords;
  logic [CntW:0]   inflight;
  logic            unused_in;

  // Bytes to words is done one bit wider than arlen so the max length cannot wrap.
  assign cmd_nwords = ({1'b0, arlen} + NW'(3)) >> 2;
  assign arready    = (state_q == ST_IDLE);
  assign accept     = arvalid & arready;
  // Reads in flight plus buffered words may never exceed the FIFO size, so
  // every response always has a slot waiting for it.
  assign inflight   = {1'b0, outst_q} + {1'b0, count_q};
  assign credit     = inflight < (CntW + 1)'(FifoDepth);
  assign req        = (state_q == ST_REQ) && (issue_cnt_q < nwords_q) && credit;
  assign issue      = req & mgr_rsp_i.gnt;
  // A response with nothing outstanding belongs to a read cut off by reset.
  assign push       = mgr_rsp_i.rvalid && (outst_q != '0);
  assign wvalid     = (count_q != '0);
  assign pop        = wvalid & wready;
  assign busy_o     = (state_q != ST_IDLE);
  assign err_o      = err_q;
  assign unused_in  = ^{mgr_rsp_i.r.rid, mgr_rsp_i.r.err, araddr[1:0]};

  // Next-state logic of the command FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = (cmd_nwords == '0) ? ST_DONE : ST_REQ;
      ST_REQ:   if (issue_cnt_d == nwords_q) state_d = ST_DRAIN;
      ST_DRAIN: if ((outst_q == '0) && (beat_cnt_q == nwords_q)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Command registers, issue/beat counters, FIFO pointers and error flag.
  always_comb begin
    addr_d      = addr_q;
    nwords_d    = nwords_q;
    tail_d      = tail_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    outst_d     = outst_q + CntW'(issue) - CntW'(push);
    count_d     = count_q + CntW'(push) - CntW'(pop);
    wptr_d      = wptr_q + PtrW'(push);
    rptr_d      = rptr_q + PtrW'(pop);
    if (accept) begin
      addr_d      = {araddr[31:2], 2'b00};
      nwords_d    = cmd_nwords;
      tail_d      = arlen[1:0];
      issue_cnt_d = '0;
      beat_cnt_d  = '0;
    end
    if (issue) begin
      addr_d      = addr_q + 32'd4;
      issue_cnt_d = issue_cnt_q + NW'(1);
    end
    if (pop) beat_cnt_d = beat_cnt_q + NW'(1);
`ifdef OBI_STREAM_READER_ERR_EN
    err_d = err_q;
    if (accept) err_d = 1'b0;
    else if (push && mgr_rsp_i.r.err) err_d = 1'b1;
`else
    err_d = 1'b0;
`endif
  end

  // OBI request: read-only, full-word, held until granted.
  always_comb begin
    mgr_req_o         = '0;
    mgr_req_o.req     = req;
    mgr_req_o.a.addr  = addr_q;
    mgr_req_o.a.be    = 4'hF;
  end

  // Stream outputs come straight from the FIFO head and the beat counter.
  always_comb begin
    wdata = mem_q[rptr_q];
    wlast = wvalid && (beat_cnt_q == nwords_q - NW'(1));
    wbe   = 4'hF;
    if (wlast) begin
      unique case (tail_q)
        2'd1:    wbe = 4'b0001;
        2'd2:    wbe = 4'b0011;
        2'd3:    wbe = 4'b0111;
        default: wbe = 4'hF;
      endcase
    end
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      nwords_q    <= '0;
      tail_q      <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      outst_q     <= '0;
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      nwords_q    <= nwords_d;
      tail_q      <= tail_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      outst_q     <= outst_d;
      count_q     <= count_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      err_q       <= err_d;
    end
  end

  // FIFO storage; contents are qualified by count_q so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= mgr_rsp_i.r.rdata;
  end

endmodule

// File: tb/tb_obi_stream_reader.sv
// Directed testbench for obi_stream_reader: an OBI subordinate model whose
// memory returns ~addr, a stream sink, and a scoreboard of expected beats.
// Build with +define+OBI_STREAM_READER_ERR_EN to cover the error flag.

module tb_obi_stream_reader;
  import obi_stream_reader_pkg::*;

  localparam int Depth = 4;
`ifdef OBI_STREAM_READER_ERR_EN
  localparam logic ErrExp = 1'b1;
`else
  localparam logic ErrExp = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  araddr = '0;
  logic [31:0]  arlen = '0;
  mgr_obi_req_t mgr_req;
  mgr_obi_rsp_t mgr_rsp = '0;
  logic         wvalid;
  logic         wready = 1'b0;
  logic [31:0]  wdata;
  logic [3:0]   wbe;
  logic         wlast;
  logic         busy;
  logic         err;

  obi_stream_reader #(.FifoDepth(Depth), .LenWidth(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .mgr_req_o(mgr_req), .mgr_rsp_i(mgr_rsp),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wbe(wbe), .wlast(wlast),
    .busy_o(busy), .err_o(err)
  );

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- bus / sink models (all act on the falling edge) ----------------
  int gnt_mode = 0;            // 0: always grant, 1: random
  int gnt_limit = 1 << 30;     // stop granting once grant_total reaches this
  int rdly_min = 0;
  int rdly_max = 0;
  int wr_mode = 0;             // 0: ready, 1: not ready, 2: random
  int ovf_base = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  int cyc = 0;
  int grant_total = 0;
  int pop_total = 0;
  logic [31:0] pend_addr_q[$];
  int          pend_rdy_q[$];
  logic [31:0] addr_log_q[$];
  logic [31:0] got_data_q[$];
  logic [3:0]  got_be_q[$];
  logic        got_last_q[$];

  bit          prev_stall = 0;
  logic [31:0] prev_addr = '0;
  bit          prev_wstall = 0;
  logic [31:0] prev_wdata = '0;
  logic [3:0]  prev_wbe = '0;
  logic        prev_wlast = 1'b0;

  always @(negedge clk) begin
    logic g;
    cyc++;
    // response channel, in order
    if (pend_addr_q.size() > 0 && pend_rdy_q[0] <= cyc) begin
      mgr_rsp.rvalid  = 1'b1;
      mgr_rsp.r.rdata = ~pend_addr_q[0];
      mgr_rsp.r.err   = (pend_addr_q[0] == err_addr);
      void'(pend_addr_q.pop_front());
      void'(pend_rdy_q.pop_front());
    end else begin
      mgr_rsp.rvalid  = 1'b0;
      mgr_rsp.r.rdata = '0;
      mgr_rsp.r.err   = 1'b0;
    end
    // request channel
    if (rst_n && prev_stall) begin
      chk("req_hold", mgr_req.req, 1'b1);
      chk("addr_hold", mgr_req.a.addr, prev_addr);
    end
    g = (grant_total < gnt_limit) && (gnt_mode == 0 || $urandom_range(0, 1) == 1);
    mgr_rsp.gnt = g;
    if (rst_n && mgr_req.req && g) begin
      chk("req_attr", {mgr_req.a.we, mgr_req.a.be, mgr_req.a.aid}, 6'b0_1111_0);
      addr_log_q.push_back(mgr_req.a.addr);
      pend_addr_q.push_back(mgr_req.a.addr);
      pend_rdy_q.push_back(cyc + 1 + int'($urandom_range(rdly_min, rdly_max)));
      grant_total++;
    end
    prev_stall = rst_n && mgr_req.req && !g;
    prev_addr  = mgr_req.a.addr;
    // stream sink
    if (rst_n && prev_wstall) begin
      chk("wvalid_hold", wvalid, 1'b1);
      chk("wdata_hold", wdata, prev_wdata);
      chk("wbe_hold", wbe, prev_wbe);
      chk("wlast_hold", wlast, prev_wlast);
    end
    wready = (wr_mode == 0) ? 1'b1 : (wr_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    if (rst_n && wvalid && wready) begin
      got_data_q.push_back(wdata);
      got_be_q.push_back(wbe);
      got_last_q.push_back(wlast);
      pop_total++;
    end
    prev_wstall = rst_n && wvalid && !wready;
    prev_wdata  = wdata;
    prev_wbe    = wbe;
    prev_wlast  = wlast;
    if (rst_n) chk("no_overflow", 32'(grant_total - pop_total - ovf_base <= Depth), 32'd1);
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] l);
    @(negedge clk);
    #1;
    arvalid = 1'b1;
    araddr  = a;
    arlen   = l;
    chk("arready_cmd", arready, 1'b1);
    @(negedge clk);
    #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      step(1);
      k++;
    end
    chk("idle_timeout", busy, 1'b0);
    chk("arready_idle", arready, 1'b1);
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic check_burst(input string tag, input logic [31:0] start, input int len);
    int nw = (len + 3) / 4;
    int tail = len % 4;
    logic [3:0] ebe;
    for (int i = 0; i < nw; i++) exp_q.push_back(start + 32'(4 * i));
    chk({tag, "_nreq"}, addr_log_q.size(), nw);
    chk({tag, "_nbeat"}, got_data_q.size(), nw);
    for (int i = 0; i < nw; i++) begin
      logic [31:0] ea;
      ea = exp_q.pop_front();
      if (addr_log_q.size() > 0) chk({tag, "_addr"}, addr_log_q.pop_front(), ea);
      if (got_data_q.size() > 0) begin
        ebe = (i == nw - 1 && tail != 0) ? 4'((1 << tail) - 1) : 4'hF;
        chk({tag, "_data"}, got_data_q.pop_front(), ~ea);
        chk({tag, "_be"}, got_be_q.pop_front(), ebe);
        chk({tag, "_last"}, got_last_q.pop_front(), (i == nw - 1));
      end
    end
    addr_log_q.delete();
    got_data_q.delete();
    got_be_q.delete();
    got_last_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    // reset values
    step(2);
    chk("rst_arready", arready, 1'b1);
    chk("rst_req", mgr_req.req, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_wlast", wlast, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    step(2);

    // T1: 16 bytes, immediate gnt/rvalid, check first-word latency
    send_cmd(32'h1000, 16);
    chk("t1_arready_busy", arready, 1'b0);
    chk("t1_busy", busy, 1'b1);
    chk("t1_req", mgr_req.req, 1'b1);
    chk("t1_addr0", mgr_req.a.addr, 32'h1000);
    step(1);
    chk("t1_wvalid_c1", wvalid, 1'b0);
    step(1);
    chk("t1_wvalid_c2", wvalid, 1'b1);
    chk("t1_wdata_c2", wdata, 32'hFFFF_EFFF);
    chk("t1_wbe_c2", wbe, 4'hF);
    wait_idle(200);
    check_burst("t1", 32'h1000, 16);

    // T2: partial last word, then zero length
    send_cmd(32'h0100, 7);
    wait_idle(200);
    check_burst("t2", 32'h0100, 7);
    send_cmd(32'h0600, 5);
    wait_idle(200);
    check_burst("t2b", 32'h0600, 5);
    send_cmd(32'h0702, 2);
    wait_idle(200);
    check_burst("t2c", 32'h0700, 2);
    send_cmd(32'h0400, 0);
    chk("t2z_arready0", arready, 1'b0);
    chk("t2z_busy", busy, 1'b1);
    chk("t2z_req", mgr_req.req, 1'b0);
    step(1);
    chk("t2z_arready1", arready, 1'b1);
    chk("t2z_idle", busy, 1'b0);
    step(3);
    chk("t2z_nreq", addr_log_q.size(), 0);
    chk("t2z_nbeat", got_data_q.size(), 0);

    // T3: sink blocked; exactly FifoDepth reads before req stops
    wr_mode = 1;
    base = grant_total;
    send_cmd(32'h5000, 40);
    step(20);
    chk("t3_grants", grant_total - base, Depth);
    chk("t3_req_low", mgr_req.req, 1'b0);
    chk("t3_wvalid", wvalid, 1'b1);
    wr_mode = 0;
    wait_idle(300);
    check_burst("t3", 32'h5000, 40);

    // T4: random grant stalls, response delays and sink back-pressure
    gnt_mode = 1;
    rdly_max = 3;
    wr_mode  = 2;
    send_cmd(32'h3000, 64);
    wait_idle(2000);
    check_burst("t4", 32'h3000, 64);
    gnt_mode = 0;
    rdly_max = 0;
    wr_mode  = 0;

    // T5: address wrap
    send_cmd(32'hFFFF_FFF8, 16);
    wait_idle(200);
    check_burst("t5", 32'hFFFF_FFF8, 16);

    // T6: reset with two reads outstanding; late responses must vanish
    rdly_min  = 3;
    rdly_max  = 3;
    base      = grant_total;
    gnt_limit = base + 2;
    send_cmd(32'h2000, 16);
    for (int k = 0; k < 50 && grant_total < base + 2; k++) step(1);
    chk("t6_two_grants", grant_total - base, 2);
    step(1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", mgr_req.req, 1'b0);
    chk("t6_rst_wvalid", wvalid, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_arready", arready, 1'b1);
    chk("t6_rst_wlast", wlast, 1'b0);
    step(1);
    rst_n = 1'b1;
    step(8);
    chk("t6_no_beat", got_data_q.size(), 0);
    chk("t6_wvalid_late", wvalid, 1'b0);
    chk("t6_pend_drained", pend_addr_q.size(), 0);
    addr_log_q.delete();
    ovf_base  = grant_total - pop_total;
    gnt_limit = 1 << 30;
    rdly_min  = 0;
    rdly_max  = 0;

    // T7: bus error on word 2; stream length unchanged
    err_addr = 32'h8004;
    send_cmd(32'h8000, 16);
    wait_idle(200);
    check_burst("t7", 32'h8000, 16);
    chk("t7_err", err, ErrExp);
    err_addr = 32'hFFFF_FFFF;
    send_cmd(32'h9000, 4);
    chk("t7_err_clr", err, 1'b0);
    wait_idle(200);
    check_burst("t7b", 32'h9000, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
